// File: rtl/sram_frame_loader.sv
// sram_frame_loader
//   Write side of the shared frame SRAM. Takes a 24-bit RGB pixel stream over a
//   valid/ready handshake, packs each pixel to RGB565 and writes one frame
//   sequentially from BASE_ADDR. Each pixel costs at least four cycles:
//   accept, address/data setup, one-cycle write strobe, hold.
//
//   Optional build macro: LOADER_CHECKSUM_EN
//     defined   -> o_checksum is the 16-bit wrapping sum of every word written
//                  since the last accepted start
//     undefined -> o_checksum is tied to 0 and no accumulator is built
//
// Ports
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_start              pulse; starts a frame load when idle
//   i_abort              pulse; terminates a load in progress
//   i_pixel              {R[7:0],G[7:0],B[7:0]}
//   i_pixel_valid        i_pixel holds a pixel
//   o_pixel_ready        pixel accepted on this cycle if i_pixel_valid
//   o_sram_writing       write strobe; the top uses it for WE_N and bus select
//   o_sram_addr          write word address
//   o_sram_data          write data, RGB565
//   o_busy               load in progress (low in IDLE and DONE)
//   o_done               one-cycle pulse after the final write
//   o_checksum           frame checksum (see macro above)
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for i_start
// ACCEPT | ready high, waiting for a pixel
// SETUP  | address/data driven, strobe low
// PULSE  | write strobe high for one cycle
// HOLD   | strobe low, address/data held; advance or finish
// DONE   | o_done pulse
module sram_frame_loader #(
  parameter int unsigned         ADDR_W    = 20,
  parameter int unsigned         FRAME_W   = 640,
  parameter int unsigned         FRAME_H   = 480,
  parameter logic [ADDR_W-1:0]   BASE_ADDR = '0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [23:0]       i_pixel,
  input  logic              i_pixel_valid,
  output logic              o_pixel_ready,
  output logic              o_sram_writing,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [15:0]       o_sram_data,
  output logic              o_busy,
  output logic              o_done,
  output logic [15:0]       o_checksum
);

  localparam int unsigned       PIX_COUNT = FRAME_W * FRAME_H;
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(PIX_COUNT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] index_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       data_q;
  logic              abort_pend_q;
  logic              ready_q, writing_q, busy_q, done_q;
  logic              take_pixel;

  // Only the upper bits of each colour survive the RGB565 packing.
  logic unused_pixel_bits;
  assign unused_pixel_bits = ^{i_pixel[18:16], i_pixel[9:8], i_pixel[2:0]};

  // An abort in the same cycle as a valid pixel wins, so the pixel is not taken.
  assign take_pixel = (state_q == S_ACCEPT) && i_pixel_valid && !i_abort;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (i_start) state_d = S_ACCEPT;
      S_ACCEPT: begin
        if (i_abort)            state_d = S_IDLE;
        else if (i_pixel_valid) state_d = S_SETUP;
      end
      S_SETUP:  state_d = i_abort ? S_IDLE : S_PULSE;
      // An abort during the strobe must not truncate the write; it is
      // remembered and honoured once the hold cycle is done.
      S_PULSE:  state_d = S_HOLD;
      S_HOLD: begin
        if (abort_pend_q || i_abort) state_d = S_IDLE;
        else if (index_q == LAST_IDX) state_d = S_DONE;
        else                          state_d = S_ACCEPT;
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Status outputs are registered from the next state so each one is a clean
  // flop output and lines up exactly with the state it describes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ready_q   <= 1'b0;
      writing_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      ready_q   <= (state_d == S_ACCEPT);
      writing_q <= (state_d == S_PULSE);
      busy_q    <= (state_d != S_IDLE) && (state_d != S_DONE);
      done_q    <= (state_d == S_DONE);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      index_q      <= '0;
      abort_pend_q <= 1'b0;
    end else begin
      if (state_q == S_IDLE && i_start) begin
        index_q <= '0;
      end else if (state_q == S_HOLD && state_d == S_ACCEPT) begin
        index_q <= index_q + 1'b1;
      end

      if (state_q == S_PULSE && i_abort) begin
        abort_pend_q <= 1'b1;
      end else if (state_q == S_IDLE) begin
        abort_pend_q <= 1'b0;
      end
    end
  end

  // Address and data only move on entry to SETUP; the read path owns the bus
  // whenever the strobe is low, so holding them elsewhere is harmless.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr_q <= '0;
      data_q <= '0;
    end else if (take_pixel) begin
      addr_q <= BASE_ADDR + index_q;
      data_q <= {i_pixel[23:19], i_pixel[15:10], i_pixel[7:3]};
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [15:0] checksum_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      checksum_q <= '0;
    end else if (state_q == S_IDLE && i_start) begin
      checksum_q <= '0;
    end else if (state_q == S_PULSE) begin
      checksum_q <= checksum_q + data_q;
    end
  end

  assign o_checksum = checksum_q;
`else
  assign o_checksum = '0;
`endif

  assign o_pixel_ready  = ready_q;
  assign o_sram_writing = writing_q;
  assign o_sram_addr    = addr_q;
  assign o_sram_data    = data_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;

endmodule

// File: tb/tb_sram_frame_loader.sv
module tb_sram_frame_loader;

  localparam int unsigned ADDR_W = 20;
  localparam logic [19:0] BASE   = 20'h100;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              valid = 1'b0;
  logic [23:0]       pixel = '0;
  logic              o_pixel_ready;
  logic              o_sram_writing;
  logic [ADDR_W-1:0] o_sram_addr;
  logic [15:0]       o_sram_data;
  logic              o_busy;
  logic              o_done;
  logic [15:0]       o_checksum;

  sram_frame_loader #(
    .ADDR_W   (ADDR_W),
    .FRAME_W  (4),
    .FRAME_H  (4),
    .BASE_ADDR(BASE)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_abort       (abort),
    .i_pixel       (pixel),
    .i_pixel_valid (valid),
    .o_pixel_ready (o_pixel_ready),
    .o_sram_writing(o_sram_writing),
    .o_sram_addr   (o_sram_addr),
    .o_sram_data   (o_sram_data),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_checksum    (o_checksum)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [19:0] wr_addr[$];
  logic [15:0] wr_data[$];
  int          acc_cyc[$];
  int          done_cnt = 0;
  int          strobe_err = 0;
  logic        wr_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Write/accept/done monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (o_sram_writing) begin
      wr_addr.push_back(o_sram_addr);
      wr_data.push_back(o_sram_data);
    end
    if (o_sram_writing && wr_prev) strobe_err <= strobe_err + 1;
    wr_prev <= o_sram_writing;
    if (o_pixel_ready && valid && !abort) acc_cyc.push_back(cyc);
    if (o_done) done_cnt <= done_cnt + 1;
  end

  function automatic logic [15:0] conv(input logic [23:0] p);
    return {p[23:19], p[15:10], p[7:3]};
  endfunction

  function automatic logic [15:0] csum_exp(input logic [15:0] s);
`ifdef LOADER_CHECKSUM_EN
    return s;
`else
    return (s & 16'h0000);
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // All drivers below run at posedge+1.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_pixel(input logic [23:0] p, input int gap);
    bit ok;
    ok = 1'b0;
    if (gap > 0) begin
      valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
    valid = 1'b1;
    pixel = p;
    for (int i = 0; i < 100; i++) begin
      if (o_pixel_ready) begin
        ok = 1'b1;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("accept_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_writes(input int n);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (wr_addr.size() >= n) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    chk("write_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (o_done) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    chk("done_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_ready();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (o_pixel_ready) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    chk("ready_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_writing();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (o_sram_writing) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    chk("strobe_timeout", 32'(ok), 32'd1);
  endtask

  logic [23:0] pix[16];
  logic [15:0] sum_all;
  logic [15:0] sum_part;
  int          done_snap;
  int          bad;
  int          t_done;

  initial begin
    for (int i = 0; i < 16; i++) begin
      pix[i] = {8'(i * 16 + 7), 8'(255 - i * 13), 8'(i * 29)};
    end
    pix[0] = 24'hFF0000;
    pix[1] = 24'h00FF00;
    sum_all = '0;
    for (int i = 0; i < 16; i++) sum_all = sum_all + conv(pix[i]);

    // Reset state
    #2;
    chk("rst_ready",    32'(o_pixel_ready),  32'd0);
    chk("rst_writing",  32'(o_sram_writing), 32'd0);
    chk("rst_addr",     32'(o_sram_addr),    32'd0);
    chk("rst_data",     32'(o_sram_data),    32'd0);
    chk("rst_busy",     32'(o_busy),         32'd0);
    chk("rst_done",     32'(o_done),         32'd0);
    chk("rst_checksum", 32'(o_checksum),     32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Frame A: two known pixels back-to-back, then random gaps
    pulse_start();
    chk("a_busy", 32'(o_busy), 32'd1);
    send_pixel(pix[0], 0);
    send_pixel(pix[1], 0);
    valid = 1'b0;
    wait_writes(2);
    chk("a_w0_addr", 32'(wr_addr[0]), 32'h100);
    chk("a_w0_data", 32'(wr_data[0]), 32'hF800);
    chk("a_w1_addr", 32'(wr_addr[1]), 32'h101);
    chk("a_w1_data", 32'(wr_data[1]), 32'h07E0);
    chk("a_csum2",   32'(o_checksum), 32'(csum_exp(16'hFFE0)));
    for (int i = 2; i < 16; i++) send_pixel(pix[i], int'($urandom_range(0, 5)));
    valid = 1'b0;
    wait_done();
    chk("a_busy_in_done", 32'(o_busy), 32'd0);
    chk("a_csum", 32'(o_checksum), 32'(csum_exp(sum_all)));
    @(posedge clk); #1;
    chk("a_done_width", 32'(o_done), 32'd0);
    chk("a_nwrites", 32'(wr_addr.size()), 32'd16);
    for (int i = 0; i < 16 && i < wr_addr.size(); i++) begin
      chk("a_addr", 32'(wr_addr[i]), 32'(BASE) + 32'(i));
      chk("a_data", 32'(wr_data[i]), 32'(conv(pix[i])));
    end
    chk("a_strobe_1cyc", 32'(strobe_err), 32'd0);
    chk("a_done_cnt", 32'(done_cnt), 32'd1);

    // Throughput: valid held high
    wr_addr.delete(); wr_data.delete(); acc_cyc.delete();
    pulse_start();
    valid = 1'b1;
    for (int i = 0; i < 16; i++) send_pixel(pix[15 - i], 0);
    valid = 1'b0;
    wait_done();
    t_done = cyc;
    chk("t_naccept", 32'(acc_cyc.size()), 32'd16);
    bad = 0;
    for (int i = 1; i < acc_cyc.size(); i++) if (acc_cyc[i] - acc_cyc[i-1] != 4) bad++;
    chk("t_interval4", 32'(bad), 32'd0);
    chk("t_done_lat", 32'(t_done - acc_cyc[0]), 32'd64);
    chk("t_nwrites", 32'(wr_addr.size()), 32'd16);
    chk("t_last_addr", 32'(wr_addr[wr_addr.size()-1]), 32'h10F);
    chk("t_last_data", 32'(wr_data[wr_data.size()-1]), 32'(conv(pix[0])));
    @(posedge clk); #1;

    // Abort in ACCEPT after three pixels; abort beats a valid pixel
    wr_addr.delete(); wr_data.delete();
    done_snap = done_cnt;
    pulse_start();
    send_pixel(pix[2], 1);
    send_pixel(pix[3], 2);
    send_pixel(pix[4], 0);
    valid = 1'b0;
    wait_ready();
    abort = 1'b1;
    valid = 1'b1;
    pixel = pix[5];
    @(posedge clk); #1;
    abort = 1'b0;
    valid = 1'b0;
    chk("ab_busy", 32'(o_busy), 32'd0);
    chk("ab_ready", 32'(o_pixel_ready), 32'd0);
    repeat (8) begin @(posedge clk); #1; end
    chk("ab_nwrites", 32'(wr_addr.size()), 32'd3);
    chk("ab_addr2", 32'(wr_addr[2]), 32'h102);
    chk("ab_no_done", 32'(done_cnt), 32'(done_snap));
    sum_part = conv(pix[2]) + conv(pix[3]) + conv(pix[4]);
    chk("ab_csum_partial", 32'(o_checksum), 32'(csum_exp(sum_part)));

    // Restart rewrites from BASE, then abort during the strobe
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    send_pixel(pix[5], 0);
    valid = 1'b0;
    wait_writes(1);
    chk("rs_addr", 32'(wr_addr[0]), 32'h100);
    chk("rs_data", 32'(wr_data[0]), 32'(conv(pix[5])));
    send_pixel(pix[6], 0);
    valid = 1'b0;
    wait_writing();
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    start = 1'b0;
    chk("ap_hold_strobe", 32'(o_sram_writing), 32'd0);
    chk("ap_hold_busy", 32'(o_busy), 32'd1);
    @(posedge clk); #1;
    chk("ap_idle_busy", 32'(o_busy), 32'd0);
    repeat (5) begin @(posedge clk); #1; end
    chk("ap_start_ignored", 32'(o_busy), 32'd0);
    chk("ap_nwrites", 32'(wr_addr.size()), 32'd2);
    chk("ap_addr1", 32'(wr_addr[1]), 32'h101);
    chk("ap_strobe_1cyc", 32'(strobe_err), 32'd0);
    chk("ap_no_done", 32'(done_cnt), 32'(done_snap));
    sum_part = conv(pix[5]) + conv(pix[6]);
    chk("ap_csum", 32'(o_checksum), 32'(csum_exp(sum_part)));

    // Async reset in the middle of a write strobe
    pulse_start();
    send_pixel(pix[7], 0);
    valid = 1'b0;
    wait_writing();
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_writing", 32'(o_sram_writing), 32'd0);
    chk("ar_busy",    32'(o_busy),         32'd0);
    chk("ar_ready",   32'(o_pixel_ready),  32'd0);
    chk("ar_addr",    32'(o_sram_addr),    32'd0);
    chk("ar_data",    32'(o_sram_data),    32'd0);
    chk("ar_done",    32'(o_done),         32'd0);
    chk("ar_csum",    32'(o_checksum),     32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
